// File: rtl/rawlcd_pkg.sv
// Shared types and helpers for the raw STN LCD scan generator.
// Holds the FSM state encoding, the FRC grayscale pattern table and a counter-width helper.
package rawlcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Indexed by {level, frame}: level 0 off, 3 on, 1 on in frame 0 only, 2 on in frames 1 and 2.
    localparam logic [15:0] FRC_PAT = 16'hF610;

    function automatic logic frc_bit(input logic [1:0] lvl, input logic [1:0] frame);
        return FRC_PAT[{lvl, frame}];
    endfunction

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int unsigned rl_clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/rawlcd_if.sv
// Pixel-word stream from the frame-buffer reader into the scan generator.
// master = word source, slave = rawlcd_scan.
interface rawlcd_if #(
    parameter int unsigned PIX_W = 4
) ();
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;

    modport master (output pix_valid, output pix_data, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_data, output pix_ready);
endinterface

// File: rtl/rawlcd_dclk_gen.sv
// Shift-clock phase divider: one 2*DCLK_DIV-clk period per pixel word.
// Phase restarts at zero whenever run_i drops, so every SHIFT entry begins with a rise strobe.
module rawlcd_dclk_gen
    import rawlcd_pkg::*;
#(
    parameter int unsigned DCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic rise_o,
    output logic fall_o,
    output logic last_o
);

    localparam int unsigned PER = 2 * DCLK_DIV;
    localparam int unsigned PW  = rl_clog2(PER);
    localparam logic [PW-1:0] PH_FALL = PW'(DCLK_DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(PER - 1);

    logic [PW-1:0] ph_q, ph_d;

    always_comb begin
        ph_d = '0;
        if (run_i && ph_q != PH_LAST) ph_d = ph_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ph_q <= '0;
        else        ph_q <= ph_d;
    end

    assign rise_o = run_i && (ph_q == '0);
    assign fall_o = run_i && (ph_q == PH_FALL);
    assign last_o = run_i && (ph_q == PH_LAST);

endmodule

// File: rtl/rawlcd_scan.sv
// Timing generator / serialiser for controller-less passive-matrix LCD panels.
// Optional GRAY_FRC_EN: 2-bit pixels rendered by 3-frame frame-rate control.
module rawlcd_scan
    import rawlcd_pkg::*;
#(
    parameter int unsigned H_RES    = 320,
    parameter int unsigned V_RES    = 240,
    parameter int unsigned BUS_W    = 4,
    parameter int unsigned DCLK_DIV = 2,
    parameter int unsigned LP_W     = 4,
    parameter int unsigned M_LINES  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    rawlcd_if.slave          pix,
    output logic [BUS_W-1:0] data,
    output logic             dclk,
    output logic             lp,
    output logic             flm,
    output logic             m,
    output logic             sof,
    output logic             underrun
);

    localparam int unsigned WORDS = H_RES / BUS_W;
    localparam int unsigned CW    = rl_clog2(WORDS);
    localparam int unsigned RW    = rl_clog2(V_RES);
    localparam int unsigned LW    = rl_clog2(LP_W);
    localparam int unsigned MW    = rl_clog2((M_LINES == 0) ? 1 : M_LINES);

    localparam logic [CW-1:0] COL_LAST = CW'(WORDS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);
    localparam logic [LW-1:0] LP_LAST  = LW'(LP_W - 1);
    localparam logic [MW-1:0] MC_LAST  = MW'((M_LINES == 0) ? 0 : M_LINES - 1);

    state_e            state_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [LW-1:0]     lcnt_q;
    logic [MW-1:0]     mcnt_q;
    logic [BUS_W-1:0]  data_q;
    logic              dclk_q, lp_q, flm_q, m_q, sof_q, und_q;
    logic [BUS_W-1:0]  px_word;
    logic              rise, fall, last;
    logic              mline_end;

    rawlcd_dclk_gen #(
        .DCLK_DIV (DCLK_DIV)
    ) u_dclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (state_q == SHIFT),
        .rise_o (rise),
        .fall_o (fall),
        .last_o (last)
    );

    // The word is taken in the same clk that opens its dclk period.
    assign pix.pix_ready = rise;

`ifdef GRAY_FRC_EN
    logic [1:0] frc_q;

    always_comb begin
        px_word = '0;
        for (int unsigned i = 0; i < BUS_W; i++)
            px_word[i] = frc_bit(pix.pix_data[2*i +: 2], frc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frc_q <= '0;
        else if (state_q == LATCH && lcnt_q == LP_LAST && row_q == ROW_LAST)
            frc_q <= (frc_q == 2'd2) ? 2'd0 : frc_q + 2'd1;
    end
`else
    assign px_word = pix.pix_data;
`endif

    assign mline_end = (M_LINES == 0) ? (row_q == ROW_LAST) : (mcnt_q == MC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            lcnt_q  <= '0;
            mcnt_q  <= '0;
            data_q  <= '0;
            dclk_q  <= 1'b0;
            lp_q    <= 1'b0;
            flm_q   <= 1'b0;
            m_q     <= 1'b0;
            sof_q   <= 1'b0;
            und_q   <= 1'b0;
        end else begin
            sof_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= SHIFT;
                        sof_q   <= 1'b1;
                        flm_q   <= 1'b1;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        data_q <= pix.pix_valid ? px_word : '0;
                        dclk_q <= 1'b1;
                        if (!pix.pix_valid) und_q <= 1'b1;
                    end
                    if (fall) dclk_q <= 1'b0;
                    if (last) begin
                        if (col_q == COL_LAST) begin
                            col_q   <= '0;
                            lcnt_q  <= '0;
                            lp_q    <= 1'b1;
                            state_q <= LATCH;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (lcnt_q == LP_LAST) begin
                        lp_q   <= 1'b0;
                        lcnt_q <= '0;
                        mcnt_q <= (mcnt_q == MC_LAST) ? '0 : mcnt_q + 1'b1;
                        if (mline_end) m_q <= ~m_q;
                        if (row_q == ROW_LAST) begin
                            row_q <= '0;
                            if (enable) begin
                                state_q <= SHIFT;
                                sof_q   <= 1'b1;
                                flm_q   <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                data_q  <= '0;
                                flm_q   <= 1'b0;
                            end
                        end else begin
                            row_q   <= row_q + 1'b1;
                            flm_q   <= 1'b0;
                            state_q <= SHIFT;
                        end
                    end else begin
                        lcnt_q <= lcnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data     = data_q;
    assign dclk     = dclk_q;
    assign lp       = lp_q;
    assign flm      = flm_q;
    assign m        = m_q;
    assign sof      = sof_q;
    assign underrun = und_q;

endmodule

// File: tb/tb_rawlcd_scan.sv
// Bench for rawlcd_scan on a 16x4 panel: per-cycle timing reference plus a data scoreboard.
// A second instance with M_LINES=1 checks the per-line AC-bias toggle.
module tb_rawlcd_scan;

    localparam int unsigned H   = 16;
    localparam int unsigned V   = 4;
    localparam int unsigned BW  = 4;
    localparam int unsigned DIV = 2;
    localparam int unsigned LPW = 4;
    localparam int unsigned LINE  = (H / BW) * 2 * DIV + LPW;
    localparam int unsigned FRAME = LINE * V;
    localparam int unsigned SHIFT_CLKS = (H / BW) * 2 * DIV;
`ifdef GRAY_FRC_EN
    localparam int unsigned PIX_W = 2 * BW;
`else
    localparam int unsigned PIX_W = BW;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic [BW-1:0] data0, data1;
    logic dclk0, lp0, flm0, m0, sof0, und0;
    logic dclk1, lp1, flm1, m1, sof1, und1;

    rawlcd_if #(.PIX_W(PIX_W)) src0 ();
    rawlcd_if #(.PIX_W(PIX_W)) src1 ();

    rawlcd_scan #(.H_RES(H), .V_RES(V), .BUS_W(BW), .DCLK_DIV(DIV), .LP_W(LPW), .M_LINES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix(src0),
        .data(data0), .dclk(dclk0), .lp(lp0), .flm(flm0), .m(m0), .sof(sof0), .underrun(und0)
    );

    rawlcd_scan #(.H_RES(H), .V_RES(V), .BUS_W(BW), .DCLK_DIV(DIV), .LP_W(LPW), .M_LINES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pix(src1),
        .data(data1), .dclk(dclk1), .lp(lp1), .flm(flm1), .m(m1), .sof(sof1), .underrun(und1)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PIX_W-1:0] pat(input int unsigned k);
        logic [PIX_W-1:0] w;
`ifdef GRAY_FRC_EN
        case (k % 4)
            0: w = 8'h55;
            1: w = 8'hAA;
            2: w = 8'hE4;
            default: w = 8'h1B;
        endcase
`else
        case (k % 4)
            0: w = 4'hA;
            1: w = 4'hB;
            2: w = 4'hC;
            default: w = 4'hD;
        endcase
`endif
        return w;
    endfunction

    function automatic logic [BW-1:0] exp_word(input logic [PIX_W-1:0] w, input int unsigned frames);
        logic [BW-1:0] r;
`ifdef GRAY_FRC_EN
        int unsigned f;
        logic [1:0] lvl;
        f = frames % 3;
        for (int unsigned i = 0; i < BW; i++) begin
            lvl = w[2*i +: 2];
            r[i] = (lvl == 2'd3) || (lvl == 2'd1 && f == 0) || (lvl == 2'd2 && f != 0);
        end
`else
        r = w;
`endif
        return r;
    endfunction

    // Reference timing: position within the frame, counted from the first SHIFT clk.
    bit          m_active = 1'b0;
    int unsigned m_pos    = 0;
    int unsigned m_frames = 0;
    bit          m_m0     = 1'b0;
    bit          m_m1     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_frames <= 0;
            m_m0     <= 1'b0;
            m_m1     <= 1'b0;
        end else if (!m_active) begin
            if (enable) begin
                m_active <= 1'b1;
                m_pos    <= 0;
            end
        end else begin
            if (m_pos % LINE == LINE - 1) m_m1 <= ~m_m1;
            if (m_pos == FRAME - 1) begin
                m_m0     <= ~m_m0;
                m_frames <= m_frames + 1;
                m_pos    <= 0;
                if (!enable) m_active <= 1'b0;
            end else begin
                m_pos <= m_pos + 1;
            end
        end
    end

    logic [BW-1:0] sb[$];
    bit exp_und    = 1'b0;
    bit drop_armed = 1'b1;
    bit prev_dclk  = 1'b0;
    int unsigned slot = 0;

    always @(negedge clk) begin
        int unsigned lpos;
        bit act;
        act  = m_active;
        lpos = m_pos % LINE;
        chk("pix_ready", src0.pix_ready, act && lpos < SHIFT_CLKS && lpos % (2*DIV) == 0);
        chk("dclk", dclk0, act && lpos < SHIFT_CLKS && lpos % (2*DIV) >= 1 && lpos % (2*DIV) <= DIV);
        chk("lp", lp0, act && lpos >= SHIFT_CLKS);
        chk("flm", flm0, act && m_pos < LINE);
        chk("sof", sof0, act && m_pos == 0);
        chk("m", m0, m_m0);
        chk("m_lines1", m1, m_m1);
        chk("underrun", und0, exp_und);
        if (!act) chk("idle_data", data0, 0);
        if (dclk0 && !prev_dclk) begin
            if (sb.size() == 0) chk("sb_empty", 1, 0);
            else                chk("data", data0, sb.pop_front());
        end
        prev_dclk <= dclk0;
    end

    // Source: one word per pix_ready, pattern indexed by slot; one slot withheld to force underrun.
    initial begin
        bit dropped;
        src1.pix_valid = 1'b1;
        src1.pix_data  = '0;
        src0.pix_valid = 1'b1;
        src0.pix_data  = pat(0);
        forever begin
            @(negedge clk);
            if (src0.pix_ready === 1'b1) begin
                sb.push_back(src0.pix_valid ? exp_word(src0.pix_data, m_frames) : '0);
                dropped = !src0.pix_valid;
                @(posedge clk);
                #1;
                if (dropped) exp_und = 1'b1;
                slot++;
                src0.pix_valid = !(drop_armed && slot == 2*(H/BW)*V/V*V/V*2 - (2*(H/BW)*V/V*V/V*2) + 38);
                src0.pix_data  = pat(slot);
            end
        end
    end

    task automatic wait_pos(input int unsigned frames, input int unsigned pos);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (m_active && m_frames == frames && m_pos == pos) found = 1'b1;
        end
        chk("wait_pos", found, 1);
    endtask

    task automatic wait_idle();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (!m_active) found = 1'b1;
        end
        chk("wait_idle", found, 1);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_data"}, data0, 0);
        chk({pfx, "_dclk"}, dclk0, 0);
        chk({pfx, "_lp"}, lp0, 0);
        chk({pfx, "_flm"}, flm0, 0);
        chk({pfx, "_m"}, m0, 0);
        chk({pfx, "_sof"}, sof0, 0);
        chk({pfx, "_underrun"}, und0, 0);
        chk({pfx, "_pix_ready"}, src0.pix_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 enable = 1'b1;

        // Underrun lands in frame 2; enable drops in row 1 of frame 3.
        wait_pos(3, LINE + 5);
        enable = 1'b0;
        wait_idle();
        repeat (8) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        chk("sof_reen", sof0, 1);

        // Asynchronous reset while dclk is high in row 1.
        wait_pos(4, LINE + 4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("mrst");
        sb.delete();
        exp_und        = 1'b0;
        drop_armed     = 1'b0;
        slot           = 0;
        src0.pix_valid = 1'b1;
        src0.pix_data  = pat(0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        wait_pos(1, 10);
        enable = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("sb_left", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
